// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter types: captured AR request, read FSM states, protocol constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi_pkg;

    // Captured AR fields are sized for the widest supported ID/address; ports cast down.
    localparam int AXI_ID_MAX   = 16;
    localparam int AXI_ADDR_MAX = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [AXI_ID_MAX-1:0]   id;
        logic [AXI_ADDR_MAX-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [1:0]              lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
    } axi_ar_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI3 port bundle (AR/R/AW/W/B); master modport drives requests, slave modport answers.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface axi_rd_arbiter_if #(
    parameter int IDW = 4,
    parameter int AW  = 32,
    parameter int DW  = 32
) ();
    logic [IDW-1:0]  arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [IDW-1:0]  awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [IDW-1:0]  wid;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last time wins.
// Latency: grant is combinational from req/en; last_grant updates on the granting edge.
// Backpressure: en low suppresses all grants and freezes last_grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    // Reset to 1 so requester 0 wins the first tie.
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges two AXI read masters onto one port, one read outstanding; m1 writes pass straight through.
// Latency: AR accepted in t appears on s_ar in t+1; R beats and the write path are combinational.
// Backpressure: owner rready drives s_rready; non-owner sees no rvalid; arready only in IDLE.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int IDW = 4,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    axi_rd_arbiter_if.slave    m0,
    axi_rd_arbiter_if.slave    m1,
    axi_rd_arbiter_if.master   s
);
    rd_state_t  st;
    axi_ar_t    ar_q;
    axi_ar_t    ar_sel;
    logic       owner;
    logic       arv_q;
    logic       ract_q;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       arb_en;
    logic       owner_rready;

    assign req    = {m1.arvalid, m0.arvalid};
    assign arb_en = resetn && (st == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .en     (arb_en),
        .gnt    (gnt)
    );

    always_comb begin
        ar_sel = '0;
        if (gnt[1]) begin
            ar_sel.id    = AXI_ID_MAX'(m1.arid);
            ar_sel.addr  = AXI_ADDR_MAX'(m1.araddr);
            ar_sel.len   = m1.arlen;
            ar_sel.size  = m1.arsize;
            ar_sel.burst = m1.arburst;
            ar_sel.lock  = m1.arlock;
            ar_sel.cache = m1.arcache;
            ar_sel.prot  = m1.arprot;
        end else begin
            ar_sel.id    = AXI_ID_MAX'(m0.arid);
            ar_sel.addr  = AXI_ADDR_MAX'(m0.araddr);
            ar_sel.len   = m0.arlen;
            ar_sel.size  = m0.arsize;
            ar_sel.burst = m0.arburst;
            ar_sel.lock  = m0.arlock;
            ar_sel.cache = m0.arcache;
            ar_sel.prot  = m0.arprot;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st     <= IDLE;
            ar_q   <= '0;
            owner  <= 1'b0;
            arv_q  <= 1'b0;
            ract_q <= 1'b0;
        end else begin
            case (st)
                IDLE: if (|gnt) begin
                    ar_q  <= ar_sel;
                    owner <= gnt[1];
                    arv_q <= 1'b1;
                    st    <= AR;
                end
                AR: if (s.arready) begin
                    arv_q  <= 1'b0;
                    ract_q <= 1'b1;
                    st     <= R;
                end
                R: if (s.rvalid && s.rready && s.rlast) begin
                    ract_q <= 1'b0;
                    st     <= IDLE;
                end
                default: begin
                    arv_q  <= 1'b0;
                    ract_q <= 1'b0;
                    st     <= IDLE;
                end
            endcase
        end
    end

    assign m0.arready = gnt[0];
    assign m1.arready = gnt[1];

    assign s.arid    = IDW'(ar_q.id);
    assign s.araddr  = AW'(ar_q.addr);
    assign s.arlen   = ar_q.len;
    assign s.arsize  = ar_q.size;
    assign s.arburst = ar_q.burst;
    assign s.arlock  = ar_q.lock;
    assign s.arcache = ar_q.cache;
    assign s.arprot  = ar_q.prot;
    assign s.arvalid = arv_q;

    // R routing follows the registered owner only; rid is never decoded.
    assign owner_rready = owner ? m1.rready : m0.rready;
    assign s.rready     = ract_q && owner_rready;

    assign m0.rid    = s.rid;
    assign m0.rdata  = DW'(s.rdata);
    assign m0.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m0.rvalid = ract_q && !owner && s.rvalid;

    assign m1.rid    = s.rid;
    assign m1.rdata  = DW'(s.rdata);
    assign m1.rresp  = s.rresp;
    assign m1.rlast  = s.rlast;
    assign m1.rvalid = ract_q && owner && s.rvalid;

    assign s.awid    = m1.awid;
    assign s.awaddr  = m1.awaddr;
    assign s.awlen   = m1.awlen;
    assign s.awsize  = m1.awsize;
    assign s.awburst = m1.awburst;
    assign s.awlock  = m1.awlock;
    assign s.awcache = m1.awcache;
    assign s.awprot  = m1.awprot;
    assign s.awvalid = m1.awvalid;
    assign m1.awready = s.awready;

    assign s.wid     = m1.wid;
    assign s.wdata   = m1.wdata;
    assign s.wstrb   = m1.wstrb;
    assign s.wlast   = m1.wlast;
    assign s.wvalid  = m1.wvalid;
    assign m1.wready = s.wready;

    assign m1.bid    = s.bid;
    assign m1.bresp  = s.bresp;
    assign m1.bvalid = s.bvalid;
    assign s.bready  = m1.bready;

    // The instruction cache never writes; its write channels are parked.
    assign m0.awready = 1'b0;
    assign m0.wready  = 1'b0;
    assign m0.bid     = '0;
    assign m0.bresp   = '0;
    assign m0.bvalid  = 1'b0;

    logic unused_m0_wr;
    assign unused_m0_wr = ^{m0.awid, m0.awaddr, m0.awlen, m0.awsize, m0.awburst, m0.awlock,
                            m0.awcache, m0.awprot, m0.awvalid, m0.wid, m0.wdata, m0.wstrb,
                            m0.wlast, m0.wvalid, m0.bready};
endmodule
